// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with debounce.
// One row is driven low at a time; the synchronized columns are sampled at
// the end of each dwell period. A single stable key is reported as a held
// level (key_valid) and a one-cycle press event (key_strobe).
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_SCAN     | rotating rows, looking for exactly one low column
// S_DEBOUNCE | row frozen, counting consecutive samples of the candidate
// S_HELD     | key accepted, row frozen, counting samples until release
module keypad_scan #(
  parameter int SCAN_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int             DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB_N      = 4'(DEBOUNCE_SAMPLES);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q;
  logic [3:0]    cs_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    row_q, row_d;
  logic [3:0]    deb_q, deb_d;
  logic [3:0]    rel_q, rel_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;

  logic          sample;
  logic [2:0]    n_low;
  logic [1:0]    col_sel;
  logic          single;
  logic          accept;
  logic          drop;

  // Two-flop column synchronizer and free-running dwell counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 4'b1111;
      cs_q    <= 4'b1111;
      dwell_q <= '0;
    end else begin
      sync1_q <= col_n;
      cs_q    <= sync1_q;
      if (dwell_q == DWELL_LAST) dwell_q <= '0;
      else                       dwell_q <= dwell_q + DW'(1);
    end
  end

  // Classify the synchronized columns: count low bits and pick the low column
  always_comb begin
    n_low   = '0;
    col_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (!cs_q[i]) begin
        n_low   = n_low + 3'd1;
        col_sel = 2'(i);
      end
    end
  end

  assign sample = (dwell_q == DWELL_LAST);
  assign single = (n_low == 3'd1);

  // State register and scan/debounce datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_SCAN;
      row_q    <= '0;
      deb_q    <= '0;
      rel_q    <= '0;
      cand_q   <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      deb_q    <= deb_d;
      rel_q    <= rel_d;
      cand_q   <= cand_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  // Next-state logic: all decisions happen only on sample cycles
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    deb_d   = deb_q;
    rel_d   = rel_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    drop    = 1'b0;
    if (sample) begin
      case (state_q)
        S_SCAN: begin
          if (single) begin
            cand_d = {row_q, col_sel};
            if (DEB_N == 4'd1) begin
              accept = 1'b1;
            end else begin
              deb_d   = 4'd1;
              state_d = S_DEBOUNCE;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (single && (col_sel == cand_q[1:0])) begin
            if ((deb_q + 4'd1) >= DEB_N) accept = 1'b1;
            else                         deb_d  = deb_q + 4'd1;
          end else begin
            deb_d   = '0;
            state_d = S_SCAN;
            row_d   = row_q + 2'd1;
          end
        end
        S_HELD: begin
          if (single && (col_sel == code_q[1:0])) begin
            rel_d = '0;
          end else if ((rel_q + 4'd1) >= DEB_N) begin
            drop    = 1'b1;
            rel_d   = '0;
            state_d = S_SCAN;
            row_d   = row_q + 2'd1;
          end else begin
            rel_d = rel_q + 4'd1;
          end
        end
        default: begin
          state_d = S_SCAN;
          row_d   = '0;
          deb_d   = '0;
          rel_d   = '0;
        end
      endcase
      if (accept) begin
        state_d = S_HELD;
        rel_d   = '0;
        deb_d   = '0;
      end
    end
    // Registered outputs: strobe lives exactly one cycle after an accept
    code_d   = accept ? cand_d : code_q;
    strobe_d = accept;
    if (accept)    valid_d = 1'b1;
    else if (drop) valid_d = 1'b0;
    else           valid_d = valid_q;
  end

  // Output logic: one-hot-low row drive and registered key reporting
  always_comb begin
    row_n        = 4'b1111;
    row_n[row_q] = 1'b0;
    key_code     = code_q;
    key_valid    = valid_q;
    key_strobe   = strobe_q;
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan. A keypad model pulls columns low for
// pressed keys in the driven row; expected row/strobe/valid timing is derived
// from sample-edge arithmetic (samples every N edges after reset).
module tb_keypad_scan;
  localparam int N = 4;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_strobe;

  logic [15:0] pressed = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          e = 0;
  int          org_e = 0;
  int          org_row = 0;
  int          e_acc = 0;
  logic [3:0]  exp_code = 4'd0;
  logic        prev_stb = 1'b0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(N), .DEBOUNCE_SAMPLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .col_n      (col_n),
    .row_n      (row_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_strobe (key_strobe)
  );

  // Keypad: every pressed key in a driven (low) row pulls its column low
  always_comb begin
    col_n = 4'b1111;
    for (int i = 0; i < 4; i++)
      if (row_n[i] === 1'b0) col_n = col_n & ~pressed[i*4 +: 4];
  end

  // Strobe must never be high on two consecutive cycles
  always @(negedge clk) begin
    if (reset_n) begin
      n_cmp++;
      if (prev_stb === 1'b1 && key_strobe === 1'b1) begin
        n_bad++;
        $display("FAIL strobe_twice: key_strobe=%b on consecutive cycles, want single pulse", key_strobe);
      end
      prev_stb = key_strobe;
    end else begin
      prev_stb = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rn_of(int r);
    logic [3:0] v;
    v = 4'b1111;
    v[r[1:0]] = 1'b0;
    return v;
  endfunction

  function automatic int model_row(int ee);
    return (org_row + (ee - org_e) / N) % 4;
  endfunction

  // Edge at which row r (not currently driven) is next sampled
  function automatic int det_edge(int r);
    int s0, k;
    s0 = e - (e % N);
    k  = (r - model_row(e) + 4) % 4;
    return s0 + k * N + N;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n) e++;
    else         e = 0;
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      tick();
      n_cmp++;
      if (row_n !== rn_of(model_row(e)) || key_valid !== 1'b0 ||
          key_strobe !== 1'b0 || key_code !== exp_code) begin
        n_bad++;
        $display("FAIL idle e=%0d: row_n=%b valid=%b strobe=%b code=%b, want row_n=%b valid=0 strobe=0 code=%b",
                 e, row_n, key_valid, key_strobe, key_code, rn_of(model_row(e)), exp_code);
      end
    end
  endtask

  task automatic run_to_accept(int r, int c, int e_det);
    logic [3:0] want_code, kc;
    int         want_row;
    kc    = {r[1:0], c[1:0]};
    e_acc = e_det + (D - 1) * N;
    while (e < e_acc) begin
      tick();
      want_row  = (e < e_det) ? model_row(e) : r;
      want_code = (e >= e_acc) ? kc : exp_code;
      n_cmp++;
      if (row_n !== rn_of(want_row) || key_strobe !== (e == e_acc) ||
          key_valid !== (e >= e_acc) || key_code !== want_code) begin
        n_bad++;
        $display("FAIL accept e=%0d acc=%0d: row_n=%b strobe=%b valid=%b code=%b, want row_n=%b strobe=%b valid=%b code=%b",
                 e, e_acc, row_n, key_strobe, key_valid, key_code, rn_of(want_row),
                 (e == e_acc), (e >= e_acc), want_code);
      end
    end
    exp_code = kc;
    tick();
    n_cmp++;
    if (key_strobe !== 1'b0 || key_valid !== 1'b1 || row_n !== rn_of(r)) begin
      n_bad++;
      $display("FAIL post_accept: strobe=%b valid=%b row_n=%b, want strobe=0 valid=1 row_n=%b",
               key_strobe, key_valid, row_n, rn_of(r));
    end
  endtask

  task automatic hold_release(int r, int c, int hold, int extra_r);
    int e_rel, e_fall, want_row;
    e_rel = e_acc + hold * N;
    while (e < e_rel) begin
      tick();
      if (extra_r >= 0 && e == e_acc + (hold / 2) * N) pressed[extra_r*4 + c] = 1'b1;
      n_cmp++;
      if (row_n !== rn_of(r) || key_valid !== 1'b1 || key_strobe !== 1'b0 || key_code !== exp_code) begin
        n_bad++;
        $display("FAIL hold e=%0d: row_n=%b valid=%b strobe=%b code=%b, want row_n=%b valid=1 strobe=0 code=%b",
                 e, row_n, key_valid, key_strobe, key_code, rn_of(r), exp_code);
      end
    end
    pressed = '0;
    e_fall = e_rel + D * N;
    while (e < e_fall) begin
      tick();
      want_row = (e < e_fall) ? r : (r + 1) % 4;
      n_cmp++;
      if (row_n !== rn_of(want_row) || key_valid !== (e < e_fall) ||
          key_strobe !== 1'b0 || key_code !== exp_code) begin
        n_bad++;
        $display("FAIL release e=%0d fall=%0d: row_n=%b valid=%b strobe=%b code=%b, want row_n=%b valid=%b strobe=0 code=%b",
                 e, e_fall, row_n, key_valid, key_strobe, key_code, rn_of(want_row), (e < e_fall), exp_code);
      end
    end
    org_e   = e_fall;
    org_row = (r + 1) % 4;
  endtask

  task automatic press_key(int r, int c, int hold, int extra_r);
    int ed;
    idle($urandom_range(0, 7));
    while (model_row(e) == r) idle(1);
    ed = det_edge(r);
    pressed[r*4 + c] = 1'b1;
    run_to_accept(r, c, ed);
    hold_release(r, c, hold, extra_r);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (row_n !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_strobe !== 1'b0) begin
        n_bad++;
        $display("FAIL reset: row_n=%b code=%b valid=%b strobe=%b, want 1110 0000 0 0",
                 row_n, key_code, key_valid, key_strobe);
      end
    end
    reset_n  = 1'b1;
    org_e    = 0;
    org_row  = 0;
    exp_code = 4'd0;
  endtask

  task automatic test_scan();
    idle(8 * N);
  endtask

  task automatic test_clean_press();
    press_key(2, 1, 2, -1);
    n_cmp++;
    if (key_code !== 4'b1001) begin
      n_bad++;
      $display("FAIL clean_code: key_code=%b, want 1001", key_code);
    end
    for (int k = 0; k < 4; k++)
      press_key($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4), -1);
  endtask

  task automatic test_bounce();
    int r, c, ed, j, e_back, want_row;
    r = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    while (model_row(e) == r) idle(1);
    ed     = det_edge(r);
    j      = $urandom_range(1, D - 1);
    e_back = ed + j * N;
    pressed[r*4 + c] = 1'b1;
    while (e < e_back) begin
      tick();
      if (e < ed)          want_row = model_row(e);
      else if (e < e_back) want_row = r;
      else                 want_row = (r + 1) % 4;
      n_cmp++;
      if (row_n !== rn_of(want_row) || key_strobe !== 1'b0 || key_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL bounce e=%0d: row_n=%b strobe=%b valid=%b, want row_n=%b strobe=0 valid=0",
                 e, row_n, key_strobe, key_valid, rn_of(want_row));
      end
      if (e == ed + (j - 1) * N) pressed = '0;
    end
    org_e   = e_back;
    org_row = (r + 1) % 4;
    idle(4 * N);
    press_key(r, c, 2, -1);
  endtask

  task automatic test_multi();
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    idle(12 * N);
    pressed = '0;
    idle(2 * N);
  endtask

  task automatic test_long_hold();
    press_key(0, 3, 50, 2);
    n_cmp++;
    if (key_code !== 4'b0011) begin
      n_bad++;
      $display("FAIL long_hold_code: key_code=%b, want 0011", key_code);
    end
    idle(2 * N);
  endtask

  task automatic test_reset_mid();
    int r, c;
    r = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    while (model_row(e) == r) idle(1);
    pressed[r*4 + c] = 1'b1;
    run_to_accept(r, c, det_edge(r));
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if (row_n !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_strobe !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: row_n=%b code=%b valid=%b strobe=%b, want 1110 0000 0 0",
               row_n, key_code, key_valid, key_strobe);
    end
    reset_n  = 1'b1;
    org_e    = 0;
    org_row  = 0;
    exp_code = 4'd0;
    run_to_accept(r, c, (r + 1) * N);
    hold_release(r, c, 2, -1);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_clean_press();
    test_bounce();
    test_bounce();
    test_multi();
    test_long_hold();
    test_reset_mid();
    idle(N);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 active-low matrix keypad, debounces it, and produces the 4-bit key code consumed by the joystick/code-entry FSM on its key_press input.
- Drives one row low at a time and samples the synchronized columns.
- Reports exactly one stable key, as a held level (key_valid) plus a single-cycle press event (key_strobe).

Parameters:
- SCAN_DIV, 50000, clk cycles each row is driven before its columns are sampled (dwell period); legal range 4 or more.
- DEBOUNCE_SAMPLES, 4, consecutive matching samples needed to accept a press or a release; legal range 1 to 15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- col_n  in  4  keypad columns, active-low, pulled up, asynchronous to clk.
- row_n  out  4  keypad row drive, exactly one bit low at all times.
- key_code  out  4  {row[1:0], col[1:0]} of the last accepted key.
- key_valid  out  1  high while the accepted key remains pressed.
- key_strobe  out  1  one-cycle pulse when a new key is accepted.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. On reset_n=0 at a clk edge:
  - row_n=4'b1110, key_code=0, key_valid=0, key_strobe=0.
  - State=S_SCAN, row index=0, dwell counter=0, debounce counter=0, synchronizer flops=4'b1111.
  - A reset asserted mid-press aborts everything. Nothing is reported until a fresh full debounce completes.
- col_n passes through a 2-flop synchronizer. All decisions use the synchronized value (cs).
- Dwell counter counts 0..SCAN_DIV-1 and wraps. A "sample" occurs in the cycle the counter equals SCAN_DIV-1.
- Sample classification:
  - Single: exactly one cs bit is 0; its index is col.
  - None: cs=4'b1111.
  - Multi: two or more bits are 0. Multi is never treated as a valid key.
- S_SCAN:
  - Single at sample: candidate={row,col}, debounce counter=1, row held (no advance), go to S_DEBOUNCE. If DEBOUNCE_SAMPLES=1, go straight to accept instead.
  - None or Multi: row index advances (3 wraps to 0) and row_n updates on the same edge.
- S_DEBOUNCE (row frozen):
  - Single with the same col: counter increments. When it reaches DEBOUNCE_SAMPLES, accept.
  - Any other sample: counter=0, return to S_SCAN, row advances.
- Accept (at the clk edge of the qualifying sample):
  - key_code=candidate, key_valid=1, key_strobe=1 for exactly the next cycle. Go to S_HELD, release counter=0.
- S_HELD (row frozen):
  - Same key sampled: release counter=0.
  - Otherwise (None, Multi, or a different col): release counter increments. At DEBOUNCE_SAMPLES, key_valid=0, go to S_SCAN, row advances.
  - No new strobe fires during S_HELD, even if a second key is added.
- key_code holds its last accepted value after release. It changes only on accept.
- key_strobe is never high for two consecutive cycles.
- A second key pressed in an unscanned row while one is held is ignored until release.
- A key in another row that appears during S_DEBOUNCE is invisible because the row is frozen. Acceptance continues.
- Latency: with a key already stable, key_strobe rises DEBOUNCE_SAMPLES-1 dwell periods after the first sample that detects it, plus one cycle.

Test Plan:
- Reset hold (SCAN_DIV=4, DEBOUNCE_SAMPLES=3): reset_n=0 for 3 cycles with col_n=4'b1111 -> row_n=1110, key_code=0, key_valid=0, key_strobe=0. Release reset -> row_n cycles 1110,1101,1011,0111 every 4 clks and wraps.
- Clean press of row 2, col 1 (model pulls col_n[1] low whenever row_n[2]=0) -> row freezes at 1011. key_strobe pulses once with key_code=4'b1001 and key_valid=1, 2 dwell periods after detection plus 1 cycle. Remove the key -> key_valid falls after 3 None samples and scanning resumes at row 3.
- Bounce: col toggles on alternate samples during S_DEBOUNCE -> no strobe, return to scan. Then hold the key stable -> exactly one strobe.
- Multi-key: col_n=4'b1100 while row 0 is driven -> never accepted, rows keep rotating, key_valid stays 0.
- Long hold of 50 dwell periods with key 4'b0011 -> exactly one strobe, key_valid high throughout. After release, key_code still reads 4'b0011.
- Reset mid-operation: assert reset_n=0 for 1 cycle during S_HELD -> all outputs return to reset values. With the key still held, a full debounce yields a new strobe.
